// File: rtl/risc_bus_pkg.sv
// risc_bus_pkg: shared bus-source constants, source indices and arbiter state type.
package risc_bus_pkg;
  localparam int N_SRC     = 32;
  localparam int SRC_IDX_W = 5;
  localparam int IDX_W     = SRC_IDX_W;
  localparam int MAX_HOLD  = 8;
  localparam int HOLD_W    = $clog2(MAX_HOLD);
  localparam logic [SRC_IDX_W-1:0] SRC_R0 = 5'd0, SRC_R1 = 5'd1, SRC_R2 = 5'd2, SRC_R3 = 5'd3;
  localparam logic [SRC_IDX_W-1:0] SRC_R4 = 5'd4, SRC_R5 = 5'd5, SRC_R6 = 5'd6, SRC_R7 = 5'd7;
  localparam logic [SRC_IDX_W-1:0] SRC_R8 = 5'd8, SRC_R9 = 5'd9, SRC_R10 = 5'd10, SRC_R11 = 5'd11;
  localparam logic [SRC_IDX_W-1:0] SRC_R12 = 5'd12, SRC_R13 = 5'd13, SRC_R14 = 5'd14, SRC_R15 = 5'd15;
  localparam logic [SRC_IDX_W-1:0] SRC_HI = 5'd16, SRC_LO = 5'd17, SRC_ZHI = 5'd18, SRC_ZLO = 5'd19;
  localparam logic [SRC_IDX_W-1:0] SRC_PC = 5'd20, SRC_MDR = 5'd21, SRC_INPORT = 5'd22, SRC_C = 5'd23;
  typedef enum logic {IDLE, OWNED} arb_state_t;
endpackage

// File: rtl/bus_source_arbiter_if.sv
// bus_source_arbiter_if: request/lock and grant signals between bus sources and the arbiter.
interface bus_source_arbiter_if;
  import risc_bus_pkg::*;
  logic [N_SRC-1:0] req;
  logic             lock;
  logic [N_SRC-1:0] grant;
  logic             grant_valid;
  modport master (output req, lock, input grant, grant_valid);
  modport slave  (input req, lock, output grant, grant_valid);
endinterface

// File: rtl/rr_pick.sv
// rr_pick: first set request at or after start, wrapping; rotate, find-first-set, un-rotate.
module rr_pick
  import risc_bus_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] winner
);
  logic [2*N_SRC-1:0] dbl;
  logic [N_SRC-1:0]   rot;
  logic [IDX_W-1:0]   off;
  always_comb begin
    dbl = {req, req} >> start;
    rot = dbl[N_SRC-1:0];
    off = '0;
    for (int i = N_SRC - 1; i >= 0; i--) off = rot[i] ? IDX_W'(i) : off;
  end
  assign found  = |req;
  assign winner = start + off;
endmodule

// File: rtl/bus_source_arbiter.sv
// bus_source_arbiter: round-robin one-hot bus-source arbiter with lock tenure.
// Define ARB_HOLD_TIMEOUT_EN to cap locked tenure at MAX_HOLD cycles when others wait.
module bus_source_arbiter
  import risc_bus_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  bus_source_arbiter_if.slave bus
);
  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d, ptr_q, ptr_d, winner;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic             grant_valid_q, found, hold;
  rr_pick u_pick (.req(bus.req), .start(ptr_q), .found(found), .winner(winner));
`ifdef ARB_HOLD_TIMEOUT_EN
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              expired, sat;
  always_comb begin
    sat     = cnt_q == HOLD_W'(MAX_HOLD - 1);
    expired = sat && |(bus.req & ~(N_SRC'(1) << owner_q));
    hold    = state_q == OWNED && bus.req[owner_q] && bus.lock && !expired;
    cnt_d   = hold ? (sat ? cnt_q : cnt_q + HOLD_W'(1)) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign hold = state_q == OWNED && bus.req[owner_q] && bus.lock;
`endif
  // Re-arbitration happens in the same cycle the hold ends, so owners change without a bubble.
  always_comb begin
    state_d = hold ? state_q : (found ? OWNED : IDLE);
    owner_d = (hold || !found) ? owner_q : winner;
    ptr_d   = (hold || !found) ? ptr_q : winner + IDX_W'(1);
    grant_d = hold ? grant_q : (found ? N_SRC'(1) << winner : '0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      ptr_q         <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      grant_valid_q <= |grant_d;
    end
  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
endmodule

// File: doc/bus_source_arbiter.md
Name: bus_source_arbiter

Overview:
- Round-robin arbiter for the 32 internal-bus source requests: register outputs, HI/LO, Z halves, PC, MDR, InPort, C.
- Produces a registered, strictly one-hot (or all-zero) 32-bit grant vector.
- The grant feeds the 32-to-5 bus-select encoder directly downstream, so the encoder only ever sees legal one-hot or zero codes.
- Supports locked multi-cycle tenure for sources that must hold the bus.

Parameters:
- N_SRC, 32, number of bus sources; width of req and grant.
- IDX_W, 5, width of the internal owner/pointer index (log2 N_SRC).
- MAX_HOLD, 8, maximum locked tenure in cycles. Used only when ARB_HOLD_TIMEOUT_EN is defined.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N_SRC  bit i set = source i requests the bus.
- lock  input  1  current owner asks to keep the bus next cycle.
- grant  output  N_SRC  registered one-hot grant; all-zero when idle.
- grant_valid  output  1  registered; high iff grant is non-zero.

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset values: grant=0, grant_valid=0, pointer ptr=0, owner=0, FSM=IDLE, tenure counter=0. Takes effect immediately on rst_n low, including mid-tenure. First arbitration is on the first clk edge after rst_n deasserts.
- Latency: 1 cycle. req sampled at edge k drives grant after edge k.
- States:
  - IDLE: no grant.
  - OWNED: grant = one-hot(owner).
- IDLE:
  - req==0 -> stay IDLE.
  - Otherwise pick the first set req bit scanning ptr, ptr+1, …, 31, 0, …, ptr-1.
  - Then owner<=winner, ptr<=(winner+1) mod 32 (31 wraps to 0), go to OWNED.
- OWNED, hold condition: req[owner]=1 AND lock=1 (AND timeout not expired, when enabled) -> hold. grant, owner and ptr unchanged.
- OWNED, re-arbitration: in all other cases, re-arbitrate in the same cycle using the IDLE rule. There is no idle bubble between owners.
  - Winner may equal the current owner, e.g. lock=0 but it is the only requester.
  - If req==0, go to IDLE with grant=0.
- Owner dropping req with lock=1: lock is ignored; re-arbitrate normally.
- lock in IDLE: no effect.
- Invariants, all cycles: $onehot0(grant); grant_valid == |grant; grant is never X.
- Fairness: with lock=0 and all 32 requesting, grant rotates 0,1,2,…,31,0 on consecutive cycles.
- Index arithmetic: unsigned IDX_W bits; the pointer increment wraps modulo N_SRC.

Optional Feature:
- Macro: ARB_HOLD_TIMEOUT_EN.
- Defined:
  - A tenure counter counts cycles the same owner has held via lock. It resets to 0 on every new grant.
  - When the counter reaches MAX_HOLD-1 and any other req bit is set, the hold condition is false and re-arbitration excludes nothing. The rotation pointer guarantees a different winner.
  - If the owner is the sole requester, the hold continues and the counter saturates at MAX_HOLD-1.
- Not defined: no counter exists; lock holds indefinitely.

Decomposition:
- Shared package risc_bus_pkg:
  - N_SRC and SRC_IDX_W constants.
  - Named source index constants (SRC_R0..SRC_R15, SRC_HI, SRC_LO, SRC_ZHI, SRC_ZLO, SRC_PC, SRC_MDR, SRC_INPORT, SRC_C), also consumed by the encoder side.
  - Arbiter state enum arb_state_t {IDLE, OWNED}.
- One combinational sub-module, rr_pick:
  - Inputs: req vector and start pointer.
  - Outputs: found flag and winner index.
  - Method: rotate, find-first-set, un-rotate.

Test Plan:
- Reset, then req=32'h0 for 3 cycles -> grant=0, grant_valid=0 every cycle.
- req=32'h0000_0011, lock=0 from reset:
  - Cycle 1: grant=32'h1, ptr=1.
  - Cycle 2: grant=32'h10.
  - Cycle 3: grant=32'h1.
- req=32'hFFFF_FFFF, lock=0 for 33 cycles -> grant walks bit 0 to bit 31, then back to bit 0 (wrap check); one-hot every cycle.
- Locked tenure and drop:
  - Owner bit 5 granted, lock=1, req=32'h0000_8020 -> grant stays 32'h20.
  - Drop req[5] -> next cycle grant=32'h8000 with no zero cycle between.
- With ARB_HOLD_TIMEOUT_EN, MAX_HOLD=8:
  - Bit 5 locked, req=32'h0000_8020 -> exactly 8 cycles of 32'h20, then 32'h8000.
  - Repeat with req=32'h20 only -> 32'h20 held indefinitely.
- Assert rst_n low mid-tenure (grant=32'h8000) between edges -> grant=0 and grant_valid=0 immediately, without a clock edge. After release, arbitration restarts from ptr=0.
